// File: rtl/piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_pkg
// Shared definitions for the parallel-in/serial-out transmit scheduler:
//   - state_t      : scheduler FSM state (IDLE / SHIFT)
//   - DEFAULT_LEN  : default parallel word width
//   - DEFAULT_NREQ : default number of requesters
//   - PARITY_BITS  : 1 when the even-parity trailer bit is built in, else 0
//   - clog2()      : ceiling log2 helper, never returns less than 1
// Configuration macro: PISO_TX_PARITY_EN (adds one even-parity bit per frame).
// -----------------------------------------------------------------------------
package piso_tx_pkg;

  localparam int DEFAULT_LEN  = 8;
  localparam int DEFAULT_NREQ = 4;

`ifdef PISO_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ceiling log2; a 1-bit minimum keeps index/counter vectors legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// -----------------------------------------------------------------------------
// piso_shifter
// Frame shift register: loads a parallel word (plus its even-parity bit when
// PISO_TX_PARITY_EN is defined) and emits it LSB first, one bit per enabled
// cycle. serial_out is registered and holds its value while shift_en is low.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   load_en    : capture load_data into the shift register (wins over shift)
//   load_data  : LEN-bit parallel word
//   shift_en   : move the next bit onto serial_out
//   serial_out : current serial bit
// Configuration macro: PISO_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module piso_shifter
  import piso_tx_pkg::*;
#(
  parameter int LEN = DEFAULT_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_en,
  input  logic [LEN-1:0] load_data,
  input  logic           shift_en,
  output logic           serial_out
);

  localparam int FRAME_BITS = LEN + PARITY_BITS;

  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic                  serial_out_q, serial_out_d;

  always_comb begin
    sreg_d       = sreg_q;
    serial_out_d = serial_out_q;
    if (load_en) begin
`ifdef PISO_TX_PARITY_EN
      // Parity rides above the MSB so it simply falls out after bit LEN-1.
      sreg_d = {^load_data, load_data};
`else
      sreg_d = load_data;
`endif
    end else if (shift_en) begin
      serial_out_d = sreg_q[0];
      sreg_d       = sreg_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q       <= '0;
      serial_out_q <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      serial_out_q <= serial_out_d;
    end
  end

  assign serial_out = serial_out_q;

endmodule

// File: rtl/piso_tx_sched.sv
// -----------------------------------------------------------------------------
// piso_tx_sched
// Round-robin scheduler feeding one shared serializer. In IDLE the next
// requester (after the last one granted) with req_valid high is granted: its
// word is captured, req_ready pulses for one cycle and the frame is shifted
// out LSB first. Frames are separated by at least one idle cycle.
// Ports:
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   req_valid    : per-requester word-available flags [NREQ]
//   req_data     : packed words, requester i at [i*LEN +: LEN]
//   req_ready    : one-hot grant pulse, high the cycle after the capture edge
//   shift_en     : 0 stalls the current frame
//   serial_out   : serialized bit
//   serial_valid : serial_out carries a frame bit
//   frame_start  : high with bit 0 of each frame
//   grant_id     : requester owning the current frame
//   busy         : capture edge through the final frame bit
// Configuration macro: PISO_TX_PARITY_EN (frame grows to LEN+1 bits).
// -----------------------------------------------------------------------------
module piso_tx_sched
  import piso_tx_pkg::*;
#(
  parameter int LEN  = DEFAULT_LEN,
  parameter int NREQ = DEFAULT_NREQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*LEN-1:0]      req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     shift_en,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     frame_start,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int GW         = clog2(NREQ);
  localparam int CW         = clog2(LEN + 2);
  localparam int FRAME_BITS = LEN + PARITY_BITS;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;          // last requester granted
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            serial_valid_q, serial_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  int              cand;
  logic            load_en;
  logic            shift_go;

  // Round-robin search starting one past the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    grant_id_d     = grant_id_q;
    req_ready_d    = '0;
    serial_valid_d = 1'b0;
    frame_start_d  = 1'b0;
    busy_d         = 1'b0;
    load_en        = 1'b0;
    shift_go       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          load_en     = 1'b1;
          req_ready_d = NREQ'(1) << win_idx;
          grant_id_d  = win_idx;
          ptr_d       = win_idx;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (shift_en) begin
          shift_go       = 1'b1;
          serial_valid_d = 1'b1;
          frame_start_d  = (cnt_q == '0);
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ptr_q          <= GW'(NREQ - 1);  // makes requester 0 first in line
      grant_id_q     <= '0;
      req_ready_q    <= '0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      req_ready_q    <= req_ready_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      busy_q         <= busy_d;
    end
  end

  piso_shifter #(
    .LEN (LEN)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_data  (req_data[int'(win_idx)*LEN +: LEN]),
    .shift_en   (shift_go),
    .serial_out (serial_out)
  );

  assign req_ready    = req_ready_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_sched
// Directed bench for piso_tx_sched (LEN=8, NREQ=4). Each grant pushes the
// expected {requester, word} onto a scoreboard queue; a monitor rebuilds every
// serial frame LSB first and pops/compares at frame end. Works with or without
// PISO_TX_PARITY_EN (expected frame width follows the package).
// -----------------------------------------------------------------------------
module tb_piso_tx_sched;
  import piso_tx_pkg::*;

  localparam int LEN  = 8;
  localparam int NREQ = 4;
  localparam int FB   = LEN + PARITY_BITS;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        shift_en;
  logic        serial_out;
  logic        serial_valid;
  logic        frame_start;
  logic [1:0]  grant_id;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // monitor state
  logic       mon_in_frame = 1'b0;
  logic       have_prev = 1'b0;
  logic       gap_check_en = 1'b0;
  int         nbits = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [8:0] word;
  logic [8:0] exp_word;
  exp_t       cur;

  piso_tx_sched #(.LEN(LEN), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic report(input string tag, input int obs, input int expv);
    errors++;
    $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else report(tag, obs, expv);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_in_frame = 1'b0;
      have_prev    = 1'b0;
    end else if (serial_valid) begin
      if (frame_start) begin
        checks++;
        assert (mon_in_frame === 1'b0) else report("frame_truncated", nbits, FB);
        if (gap_check_en && have_prev) begin
          checks++;
          assert ((cyc - last_cyc) === 2) else report("frame_gap", cyc - last_cyc - 1, 1);
        end
        checks++;
        assert (exp_q.size() > 0) else report("unexpected_frame", int'(grant_id), 0);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          checks++;
          assert (grant_id === cur.id) else report("grant_id", int'(grant_id), int'(cur.id));
        end else begin
          cur = '0;
        end
        mon_in_frame = 1'b1;
        nbits        = 0;
        word         = '0;
      end else begin
        checks++;
        assert (mon_in_frame === 1'b1) else report("stray_bit", int'(serial_out), 0);
      end
      if (mon_in_frame) begin
        word[nbits] = serial_out;
        nbits++;
        if (nbits == FB) begin
          exp_word = {1'b0, cur.data};
          if (PARITY_BITS == 1) exp_word[8] = ^cur.data;
          checks++;
          assert (word === exp_word) else report("frame_word", int'(word), int'(exp_word));
          $display("frame req=%0d word=%0h expected=%0h", cur.id, word, exp_word);
          mon_in_frame = 1'b0;
          have_prev    = 1'b1;
          last_cyc     = cyc;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input logic [3:0] exp_oh, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == 4'b0 && n < 60);
    chk(tag, int'(req_ready), int'(exp_oh));
    $display("grant %s req_ready=%b", tag, req_ready);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !mon_in_frame && !busy) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, int'(exp_q.size() == 0 && !mon_in_frame && !busy), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_serial_out"}, int'(serial_out), 0);
    chk({tag, "_serial_valid"}, int'(serial_valid), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_grant_id"}, int'(grant_id), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] held;
  int         order [5];

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_data  = '0;
    shift_en  = 1'b1;
    order     = '{0, 1, 2, 3, 0};

    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // single request from requester 0, 0xA5
    req_data[7:0] = 8'hA5;
    push(2'd0, 8'hA5);
    req_valid = 4'b0001;
    wait_grant(4'b0001, "single");
    chk("single_busy", int'(busy), 1);
    req_valid = 4'b0;
    tick();
    chk("single_ready_pulse", int'(req_ready), 0);
    chk("single_first_bit", int'(serial_out), 1);
    chk("single_first_valid", int'(frame_start), 1);
    wait_idle("single_done");

    // all four requesting: order 0,1,2,3,0 with one-cycle gaps
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int g = 0; g < 5; g++) push(2'(order[g]), req_data[8*order[g] +: 8]);
    gap_check_en = 1'b1;
    req_valid    = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(4'b0001 << order[g], "all_rr");
      if (g == 4) req_valid = 4'b0;
    end
    wait_idle("all_done");
    gap_check_en = 1'b0;

    // stall for three cycles after bit 2 of 0xF0
    req_data[7:0] = 8'hF0;
    push(2'd0, 8'hF0);
    req_valid = 4'b0001;
    wait_grant(4'b0001, "stall");
    req_valid = 4'b0;
    repeat (3) tick();
    chk("stall_bit2_valid", int'(serial_valid), 1);
    chk("stall_bit2", int'(serial_out), 0);
    held     = {3'b0, serial_out};
    shift_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_valid_low", int'(serial_valid), 0);
      chk("stall_out_held", int'(serial_out), int'(held[0]));
      chk("stall_busy", int'(busy), 1);
    end
    shift_en = 1'b1;
    wait_idle("stall_done");

    // reset at bit 4 of 0x3C from requester 3, then 2 beats pending 3
    req_data[31:24] = 8'h3C;
    push(2'd3, 8'h3C);
    req_valid = 4'b1000;
    wait_grant(4'b1000, "abort");
    repeat (5) tick();
    chk("abort_bit4_valid", int'(serial_valid), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    req_data[23:16] = 8'h5A;
    req_valid       = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    push(2'd2, 8'h5A);
    push(2'd3, 8'h3C);
    wait_grant(4'b0100, "after_reset_2");
    req_valid = 4'b1000;
    wait_grant(4'b1000, "after_reset_3");
    req_valid = 4'b0;
    wait_idle("abort_done");

    // requester 1 withdraws during requester 0's frame
    req_data[7:0]   = 8'h96;
    req_data[15:8]  = 8'h69;
    req_data[23:16] = 8'hC3;
    push(2'd0, 8'h96);
    push(2'd2, 8'hC3);
    req_valid = 4'b0011;
    wait_grant(4'b0001, "drop_0");
    tick();
    req_valid = 4'b0100;
    wait_grant(4'b0100, "drop_skip_1");
    req_valid = 4'b0;
    wait_idle("drop_done");

    // frame length / parity with 0x07
    req_data[15:8] = 8'h07;
    push(2'd1, 8'h07);
    req_valid = 4'b0010;
    wait_grant(4'b0010, "parity");
    req_valid = 4'b0;
    wait_idle("parity_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
